// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide
// sequencer. The pipeline side drives the request and reads busy/done/results.
interface muldiv_seq_if #(
   parameter int N = 32
);
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] hi;
   logic [N-1:0] lo;
   logic         div_by_zero;

   modport master (
      output start, op, A, B,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, A, B,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. Works on operand magnitudes with a
// shift-add multiply or restoring divide (one step per cycle through a small
// add/subtract ALU), applies sign correction once, then pulses done with the
// result held in hi/lo until the next operation's fix-up cycle.

// Minimal add/subtract ALU. cout is the carry out for add and the borrow for
// subtract (bit N of the zero-extended difference).
module muldiv_alu #(
   parameter int N = 32
) (
   input  logic [4:0]   alu_fn,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y,
   output logic         cout
);
   localparam logic [4:0] ALU_ADD = 5'b00001;
   localparam logic [4:0] ALU_SUB = 5'b10001;

   // Single-step arithmetic selected by the function code.
   always_comb begin
      // NOTE: outputs get a default before the case so unlisted codes cannot infer a latch.
      y    = '0;
      cout = 1'b0;
      case (alu_fn)
         ALU_ADD: {cout, y} = {1'b0, a} + {1'b0, b};
         ALU_SUB: {cout, y} = {1'b0, a} - {1'b0, b};
         default: ;
      endcase
   end
endmodule

module muldiv_seq #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_seq_if.slave  bus
);
   localparam int            CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [4:0]    ALU_ADD  = 5'b00001;
   localparam logic [4:0]    ALU_SUB  = 5'b10001;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          div_q, div_d;          // operation is a divide
   logic [N-1:0]  opnd_q, opnd_d;        // |A| for multiply, |B| for divide
   logic [N-1:0]  acc_hi_q, acc_hi_d;    // product high half / remainder
   logic [N-1:0]  acc_lo_q, acc_lo_d;    // multiplier+product low / quotient
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_res_q, neg_res_d;  // operand signs differ (signed ops)
   logic          neg_rem_q, neg_rem_d;  // dividend negative (signed divide)
   logic          dbz_op_q, dbz_op_d;    // divide with zero divisor
   logic [N-1:0]  a_raw_q, a_raw_d;      // raw dividend for the divide-by-zero result
   logic [N-1:0]  hi_q, hi_d;
   logic [N-1:0]  lo_q, lo_d;
   logic          dbz_q, dbz_d;

   logic [4:0]    alu_fn;
   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_y;
   logic          alu_cout;
   logic [N:0]    div_shift;
   logic [N:0]    mul_sum;
   logic          sign_a, sign_b;
   logic [N-1:0]  mag_a, mag_b;
   logic [2*N-1:0] prod;

   muldiv_alu #(.N(N)) u_alu (
      .alu_fn (alu_fn),
      .a      (alu_a),
      .b      (opnd_q),
      .y      (alu_y),
      .cout   (alu_cout)
   );

   // ALU operand steering: add the multiplicand, or trial-subtract the divisor
   // from the left-shifted remainder (the bit shifted out is kept as bit N).
   always_comb begin
      div_shift = {acc_hi_q, acc_lo_q[N-1]};
      if (div_q) begin
         alu_a  = div_shift[N-1:0];
         alu_fn = ALU_SUB;
      end else begin
         alu_a  = acc_hi_q;
         alu_fn = ALU_ADD;
      end
   end

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      opnd_d    = opnd_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_op_d  = dbz_op_q;
      a_raw_d   = a_raw_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;
      mul_sum   = '0;
      prod      = '0;

      // Magnitudes: the most negative value maps to 2^(N-1) as an unsigned number.
      sign_a = bus.A[N-1] & ~bus.op[0];
      sign_b = bus.B[N-1] & ~bus.op[0];
      mag_a  = sign_a ? -bus.A : bus.A;
      mag_b  = sign_b ? -bus.B : bus.B;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               div_d     = bus.op[1];
               opnd_d    = bus.op[1] ? mag_b : mag_a;
               acc_hi_d  = '0;
               acc_lo_d  = bus.op[1] ? mag_a : mag_b;
               cnt_d     = '0;
               neg_res_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               dbz_op_d  = bus.op[1] && (bus.B == '0);
               a_raw_d   = bus.A;
               dbz_d     = 1'b0;
               state_d   = S_CALC;
            end
         end

         S_CALC: begin
            if (div_q) begin
               // No borrow when the shifted-out bit is set or the subtract fits.
               if (div_shift[N] || !alu_cout) begin
                  acc_hi_d = alu_y;
                  acc_lo_d = {acc_lo_q[N-2:0], 1'b1};
               end else begin
                  acc_hi_d = div_shift[N-1:0];
                  acc_lo_d = {acc_lo_q[N-2:0], 1'b0};
               end
            end else begin
               mul_sum  = acc_lo_q[0] ? {alu_cout, alu_y} : {1'b0, acc_hi_q};
               acc_hi_d = mul_sum[N:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[N-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            if (div_q) begin
               if (dbz_op_q) begin
                  lo_d  = '1;
                  hi_d  = a_raw_q;
                  dbz_d = 1'b1;
               end else begin
                  lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                  hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
               end
            end else begin
               prod = {acc_hi_q, acc_lo_q};
               if (neg_res_q) begin
                  prod = -prod;
               end
               {hi_d, lo_d} = prod;
            end
            state_d = S_DONE;
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= S_IDLE;
         div_q     <= 1'b0;
         opnd_q    <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_op_q  <= 1'b0;
         a_raw_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         opnd_q    <= opnd_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_op_q  <= dbz_op_d;
         a_raw_q   <= a_raw_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
      end
   end

   assign bus.busy        = (state_q == S_CALC) || (state_q == S_FIX);
   assign bus.done        = (state_q == S_DONE);
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases with hand-computed results,
// random cases against an arithmetic reference, restart and reset-abort timing.
module tb_muldiv_seq;
   localparam int N = 32;

   typedef struct {
      string        name;
      logic [N-1:0] hi;
      logic [N-1:0] lo;
      logic         dbz;
      int           done_cyc;
   } exp_t;

   typedef struct packed {
      logic [1:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] hi;
      logic [N-1:0] lo;
      logic         dbz;
   } dir_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_seq_if #(.N(N)) bus ();

   muldiv_seq #(.N(N)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   int   n_assert = 0;
   int   n_fail   = 0;
   int   edge_cnt = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   logic busy_prev = 1'b0;
   dir_t dir_tab [14];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic in 64-bit integers.
   function automatic exp_t model(input string name, input logic [1:0] op,
                                  input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t        e;
      longint      sa, sb, p, q, r;
      logic [63:0] pu;
      e.name     = name;
      e.dbz      = 1'b0;
      e.done_cyc = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin
            p = sa * sb;
            e.hi = p[2*N-1:N];
            e.lo = p[N-1:0];
         end
         2'b01: begin
            pu = {32'd0, a} * {32'd0, b};
            e.hi = pu[2*N-1:N];
            e.lo = pu[N-1:0];
         end
         2'b10: begin
            if (b == '0) begin
               e.lo = '1; e.hi = a; e.dbz = 1'b1;
            end else begin
               q = sa / sb;
               r = sa % sb;
               e.lo = q[N-1:0];
               e.hi = r[N-1:0];
            end
         end
         default: begin
            if (b == '0) begin
               e.lo = '1; e.hi = a; e.dbz = 1'b1;
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Drives a one-cycle start from the current negedge and queues the expectation.
   task automatic issue_exp(input string name, input logic [1:0] op, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [N-1:0] hi,
                            input logic [N-1:0] lo, input logic dbz);
      exp_t e;
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      e.name     = name;
      e.hi       = hi;
      e.lo       = lo;
      e.dbz      = dbz;
      e.done_cyc = edge_cnt + N + 2;
      sb_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      check({name, ":busy_start"}, bus.busy, 1);
   endtask

   task automatic issue(input string name, input logic [1:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      e = model(name, op, a, b);
      issue_exp(name, op, a, b, e.hi, e.lo, e.dbz);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (sb_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (sb_q.size() != 0) begin
         check("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_until(input int cyc);
      while (edge_cnt < cyc) @(negedge clk);
   endtask

   // Result monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", bus.done, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check({mon_e.name, ":hi"}, bus.hi, mon_e.hi);
               check({mon_e.name, ":lo"}, bus.lo, mon_e.lo);
               check({mon_e.name, ":dbz"}, bus.div_by_zero, mon_e.dbz);
               check({mon_e.name, ":latency"}, edge_cnt, mon_e.done_cyc);
               check({mon_e.name, ":busy_done"}, bus.busy, 0);
               check({mon_e.name, ":busy_before"}, busy_prev, 1);
            end
         end
         busy_prev = bus.busy;
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got no end of test, expected end within 20000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      int k0;
      logic [1:0]   rop;
      logic [N-1:0] ra, rb;

      dir_tab = '{
         '{2'b01, 32'd7,          32'd6,          32'h0,          32'h2A,         1'b0},
         '{2'b00, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  1'b0},
         '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h1,          1'b0},
         '{2'b11, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0},
         '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0},
         '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0},
         '{2'b11, 32'h1234,       32'd0,          32'h1234,       32'hFFFF_FFFF,  1'b1},
         '{2'b01, 32'd2,          32'd3,          32'h0,          32'd6,          1'b0},
         '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0},
         '{2'b10, 32'd7,          32'd0,          32'd7,          32'hFFFF_FFFF,  1'b1},
         '{2'b10, 32'h8000_0000,  32'd2,          32'h0,          32'hC000_0000,  1'b0},
         '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  1'b0},
         '{2'b11, 32'hFFFF_FFFF,  32'd1,          32'h0,          32'hFFFF_FFFF,  1'b0},
         '{2'b11, 32'd5,          32'hFFFF_FFFF,  32'd5,          32'h0,          1'b0}
      };

      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.A     = '0;
      bus.B     = '0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      check("reset:busy", bus.busy, 0);
      check("reset:done", bus.done, 0);
      check("reset:hi", bus.hi, 0);
      check("reset:lo", bus.lo, 0);
      check("reset:dbz", bus.div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases with hand-computed results.
      foreach (dir_tab[i]) begin
         issue_exp($sformatf("dir%0d", i), dir_tab[i].op, dir_tab[i].a, dir_tab[i].b,
                   dir_tab[i].hi, dir_tab[i].lo, dir_tab[i].dbz);
         wait_drain(N + 10);
      end

      // Starts while busy and in the done cycle are ignored; the next cycle restarts.
      k0 = edge_cnt;
      issue("mulu_7x6_hold", 2'b01, 32'd7, 32'd6);
      wait_until(k0 + 5);
      bus.start = 1'b1; bus.op = 2'b11; bus.A = 32'd9; bus.B = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(k0 + N + 2);
      check("restart:done_cycle", bus.done, 1);
      bus.start = 1'b1; bus.op = 2'b11; bus.A = 32'd9; bus.B = 32'd3;
      @(negedge clk);
      check("restart:busy_after_done", bus.busy, 0);
      issue_exp("divu_9_3_restart", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
      wait_drain(N + 10);

      // Reset mid-operation aborts without a done pulse and clears the results.
      k0 = edge_cnt;
      issue("mult_abort", 2'b00, 32'hFFFF_FFFB, 32'd9);
      wait_until(k0 + 10);
      rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort:busy", bus.busy, 0);
      check("abort:done", bus.done, 0);
      check("abort:hi", bus.hi, 0);
      check("abort:lo", bus.lo, 0);
      issue_exp("mult_after_reset", 2'b00, 32'hFFFF_FFF9, 32'd3,
                32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      wait_drain(N + 10);

      // Random operations against the reference model.
      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 5) == 0) rb = '0;
         else if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
         issue($sformatf("rand%0d", i), rop, ra, rb);
         wait_drain(N + 10);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
